// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and the memory.
// The fetch stage is the master. The memory answers in request order.
interface fetch_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Fetch frontend: owns the fetch PC, keeps in-order imem requests within buffer credits,
// buffers returned words, feeds decode, and squashes in-flight fetches on redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  fetch_stage_if.master imem,
  output logic [31:0]   pc2,
  output logic [31:0]   instr2,
  output logic          valid2
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {FETCH, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   buf_pc_q [BUF_DEPTH];
  logic [31:0]   buf_pc_d [BUF_DEPTH];
  logic [31:0]   buf_instr_q [BUF_DEPTH];
  logic [31:0]   buf_instr_d [BUF_DEPTH];
  logic [31:0]   pc2_q, pc2_d;
  logic [31:0]   instr2_q, instr2_d;
  logic          valid2_q, valid2_d;

  logic          credit_ok;
  logic          req_fire;
  logic          rsp_fire;
  logic          push;
  logic          bypass;
  logic          pop;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] drop_base;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    buf_pc_d      = buf_pc_q;
    buf_instr_d   = buf_instr_q;
    pc2_d         = pc2_q;
    instr2_d      = instr2_q;
    valid2_d      = valid2_q;
    push          = 1'b0;
    bypass        = 1'b0;
    pop           = 1'b0;
    drop_base     = '0;

    credit_ok           = (int'(outstanding_q) + int'(count_q)) < BUF_DEPTH;
    imem.imem_req_valid = !rst && (state_q == FETCH) && credit_ok && !redirect_valid;
    imem.imem_addr      = fetch_pc_q;
    req_fire            = imem.imem_req_valid && imem.imem_req_ready;
    rsp_fire            = imem.imem_rsp_valid;
    outstanding_d       = outstanding_q + CW'(req_fire) - CW'(rsp_fire);
    // Outstanding requests are consecutive words ending just below fetch_pc, so the
    // oldest one (the one answering now) sits outstanding*4 bytes back.
    rsp_pc              = fetch_pc_q - (32'(outstanding_q) << 2);

    if (redirect_valid) begin
      drop_base  = (state_q == FETCH) ? outstanding_q : drop_cnt_q;
      drop_cnt_d = drop_base - CW'(rsp_fire);
      state_d    = (drop_cnt_d != '0) ? DRAIN : FETCH;
      fetch_pc_d = redirect_pc;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      pc2_d      = redirect_pc;
      instr2_d   = NOP_INSTR;
      valid2_d   = 1'b0;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (state_q == DRAIN) begin
        if (rsp_fire) begin
          drop_cnt_d = drop_cnt_q - CW'(1);
          if (drop_cnt_q == CW'(1)) begin
            state_d = FETCH;
          end
        end
      end else begin
        push = rsp_fire;
      end
      if (!stall) begin
        if (count_q != '0) begin
          pc2_d    = buf_pc_q[rd_ptr_q];
          instr2_d = buf_instr_q[rd_ptr_q];
          valid2_d = 1'b1;
          pop      = 1'b1;
          rd_ptr_d = rd_ptr_q + PW'(1);
        end else if (push) begin
          pc2_d    = rsp_pc;
          instr2_d = imem.imem_rdata;
          valid2_d = 1'b1;
          bypass   = 1'b1;
        end else begin
          instr2_d = NOP_INSTR;
          valid2_d = 1'b0;
        end
      end
      if (push && !bypass) begin
        buf_pc_d[wr_ptr_q]    = rsp_pc;
        buf_instr_d[wr_ptr_q] = imem.imem_rdata;
        wr_ptr_d              = wr_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push && !bypass) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      pc2_q         <= RESET_PC;
      instr2_q      <= NOP_INSTR;
      valid2_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      pc2_q         <= pc2_d;
      instr2_q      <= instr2_d;
      valid2_q      <= valid2_d;
    end
  end

  // Buffer storage needs no reset: occupancy alone decides what is meaningful.
  always_ff @(posedge clk) begin
    buf_pc_q    <= buf_pc_d;
    buf_instr_q <= buf_instr_d;
  end

  assign pc2    = pc2_q;
  assign instr2 = instr2_q;
  assign valid2 = valid2_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: in-order memory model with variable latency,
// expected-instruction queue checked by a monitor, plus direct control checks.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc2;
  logic [31:0] instr2;
  logic        valid2;

  fetch_stage_if imem_bus();

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .BUF_DEPTH(2),
    .NOP_INSTR(NOP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem          (imem_bus.master),
    .pc2           (pc2),
    .instr2        (instr2),
    .valid2        (valid2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  mem_req_t mem_q[$];
  exp_t     exp_q[$];
  int       checks  = 0;
  int       errors  = 0;
  int       cyc     = 0;
  int       mem_lat = 1;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5EED_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic rv,
                               input logic [31:0] rpc, input logic rdy);
    rst                     = r;
    stall                   = s;
    redirect_valid          = rv;
    redirect_pc             = rpc;
    imem_bus.imem_req_ready = rdy;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expectPc(input logic [31:0] pc);
    exp_q.push_back('{pc, instr_of(pc)});
  endtask

  // In-order memory: accepted requests are answered mem_lat cycles later, one per cycle.
  initial begin
    imem_bus.imem_rsp_valid = 1'b0;
    imem_bus.imem_rdata     = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc + 1) begin
        imem_bus.imem_rsp_valid = 1'b1;
        imem_bus.imem_rdata     = instr_of(mem_q[0].addr);
      end else begin
        imem_bus.imem_rsp_valid = 1'b0;
        imem_bus.imem_rdata     = '0;
      end
      @(negedge clk);
      if (rst) begin
        mem_q.delete();
      end else begin
        if (imem_bus.imem_rsp_valid) mem_q.delete(0);
        if (imem_bus.imem_req_valid && imem_bus.imem_req_ready)
          mem_q.push_back('{imem_bus.imem_addr, cyc + 1 + mem_lat});
      end
    end
  end

  // Monitor: each newly presented instruction must be the next expected one;
  // a stalled cycle must keep showing the previous one.
  initial begin
    logic        prev_stall  = 1'b0;
    logic        prev_redir  = 1'b0;
    logic        prev_rst    = 1'b1;
    logic        prev_valid2 = 1'b0;
    logic [31:0] last_pc     = '0;
    logic [31:0] last_instr  = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (valid2 === 1'b1) begin
        if (prev_stall && !prev_redir && !prev_rst && prev_valid2) begin
          checkOutput("hold_pc2", pc2, last_pc);
          checkOutput("hold_instr2", instr2, last_instr);
        end else if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_valid2: got pc2 %h, expected no instruction (cycle %0d)", pc2, cyc);
        end else begin
          e = exp_q.pop_front();
          checkOutput("sb_pc2", pc2, e.pc);
          checkOutput("sb_instr2", instr2, e.instr);
          last_pc    = e.pc;
          last_instr = e.instr;
        end
      end
      prev_stall  = stall;
      prev_redir  = redirect_valid;
      prev_rst    = rst;
      prev_valid2 = (valid2 === 1'b1);
    end
  end

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    expectPc(32'h0);
    expectPc(32'h4);
    expectPc(32'h8);
    tick(2);
    checkOutput("reset_pc2", pc2, 32'h0);
    checkOutput("reset_instr2", instr2, NOP);
    checkOutput("reset_valid2", {31'b0, valid2}, 32'h0);
    checkOutput("reset_req_valid", {31'b0, imem_bus.imem_req_valid}, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    checkOutput("first_req_valid", {31'b0, imem_bus.imem_req_valid}, 32'h1);
    checkOutput("first_addr", imem_bus.imem_addr, 32'h0);
    tick(1);
    checkOutput("no_valid_yet", {31'b0, valid2}, 32'h0);
    checkOutput("second_addr", imem_bus.imem_addr, 32'h4);
    tick(3);

    // stall three cycles while pc2=0x8; the buffer fills and requests stop
    expectPc(32'hC);
    expectPc(32'h10);
    expectPc(32'h14);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
    tick(1);
    checkOutput("stall_req_off_a", {31'b0, imem_bus.imem_req_valid}, 32'h0);
    tick(1);
    checkOutput("stall_req_off_b", {31'b0, imem_bus.imem_req_valid}, 32'h0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    tick(2);

    // memory not ready for four cycles
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("notready_addr_a", imem_bus.imem_addr, 32'h18);
    tick(2);
    checkOutput("notready_valid2", {31'b0, valid2}, 32'h0);
    checkOutput("notready_instr2", instr2, NOP);
    checkOutput("notready_addr_b", imem_bus.imem_addr, 32'h18);
    checkOutput("notready_req", {31'b0, imem_bus.imem_req_valid}, 32'h1);
    tick(2);
    checkOutput("notready_addr_c", imem_bus.imem_addr, 32'h18);

    // latency 3, redirect to 0x100 with two requests in flight
    mem_lat = 3;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    tick(2);
    expectPc(32'h100);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h100, 1'b1);
    #1;
    checkOutput("redir_req_off", {31'b0, imem_bus.imem_req_valid}, 32'h0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("redir_pc2", pc2, 32'h100);
    checkOutput("redir_valid2", {31'b0, valid2}, 32'h0);
    checkOutput("redir_instr2", instr2, NOP);
    #1;
    checkOutput("drain_req_off_a", {31'b0, imem_bus.imem_req_valid}, 32'h0);
    tick(1);
    checkOutput("drain_req_off_b", {31'b0, imem_bus.imem_req_valid}, 32'h0);
    tick(1);
    checkOutput("post_drain_req", {31'b0, imem_bus.imem_req_valid}, 32'h1);
    checkOutput("post_drain_addr", imem_bus.imem_addr, 32'h100);
    tick(4);

    // redirect together with stall, to the top of the address space
    expectPc(32'hFFFF_FFFC);
    expectPc(32'h0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
    tick(1);
    checkOutput("redir_stall_pc2", pc2, 32'hFFFF_FFFC);
    checkOutput("redir_stall_valid2", {31'b0, valid2}, 32'h0);
    mem_lat = 1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    checkOutput("wrap_addr_a", imem_bus.imem_addr, 32'hFFFF_FFFC);
    tick(1);
    checkOutput("wrap_addr_b", imem_bus.imem_addr, 32'h0);
    tick(2);

    // reset in the middle of streaming
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    tick(1);
    checkOutput("midrst_pc2", pc2, 32'h0);
    checkOutput("midrst_valid2", {31'b0, valid2}, 32'h0);
    checkOutput("midrst_instr2", instr2, NOP);
    expectPc(32'h0);
    expectPc(32'h4);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    #1;
    checkOutput("restart_req", {31'b0, imem_bus.imem_req_valid}, 32'h1);
    checkOutput("restart_addr", imem_bus.imem_addr, 32'h0);
    tick(2);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(4);
    checkOutput("expected_left", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
